uart_rx_fifo: RTL

//  Buffer sitting directly downstream of the UART receiver. Takes each received byte
//  (rByte level + rData), acks it via the BUSY pulse and stores it in a DEPTH-entry FIFO.

---
 rtl/uart_rx_fifo_pkg.sv | 10 +
 rtl/uart_rx_fifo_if.sv | 31 +++
 rtl/uart_fifo_mem.sv | 27 ++
 rtl/uart_rx_fifo.sv | 102 ++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared constants for the UART receive FIFO
package uart_rx_fifo_pkg;

    localparam int DWL_DEF = 8;

    localparam logic [1:0] S_Idle = 2'd0;
    localparam logic [1:0] S_Ack  = 2'd1;
    localparam logic [1:0] S_Wait = 2'd2;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver-side and host-side signals of the receive FIFO
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int DWL   = DWL_DEF,
    parameter int DEPTH = 16
) ();

    localparam int AW = $clog2(DEPTH);

    logic           rByte;
    logic [DWL-1:0] rData;
    logic           BUSY;
    logic           rdValid;
    logic [DWL-1:0] rdData;
    logic           rdReady;
    logic [AW:0]    count;
    logic           overflow;
    logic           clrOvf;

    modport master (
        output rByte, rData, rdReady, clrOvf,
        input  BUSY, rdValid, rdData, count, overflow
    );

    modport slave (
        input  rByte, rData, rdReady, clrOvf,
        output BUSY, rdValid, rdData, count, overflow
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x DWL register file, one sync write, one async read
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int DWL   = DWL_DEF,
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DWL-1:0]           wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DWL-1:0]           rdata
);

    logic [DWL-1:0] mem [DEPTH];

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive buffer: ack FSM, FWFT FIFO, sticky overflow
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DWL   = DWL_DEF,
    parameter int DEPTH = 16
) (
    input  logic          CLK,
    input  logic          RST,
    uart_rx_fifo_if.slave bus
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [1:0]    state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_nxt;
    logic          busy_r;
    logic          valid_r;
    logic          ovf_r;
    logic          full;
    logic          pop;
    logic          push;
    logic          blocked;

    // Push is only accepted from idle; a full FIFO still accepts when a pop frees a slot.
    always_comb begin
        full    = (cnt == FULL_CNT);
        pop     = valid_r && bus.rdReady;
        push    = (state == S_Idle) && bus.rByte && (!full || pop);
        blocked = (state == S_Idle) && bus.rByte && full && !pop;
        cnt_nxt = cnt;
        if (push && !pop) begin
            cnt_nxt = cnt + 1'b1;
        end else if (pop && !push) begin
            cnt_nxt = cnt - 1'b1;
        end
    end

    // Ack FSM: one-cycle BUSY, then hold off until the receiver drops rByte.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_Idle;
            busy_r <= 1'b0;
        end else begin
            busy_r <= push;
            case (state)
                S_Idle:  if (push) state <= S_Ack;
                S_Ack:   state <= S_Wait;
                S_Wait:  if (!bus.rByte) state <= S_Idle;
                default: state <= S_Idle;
            endcase
        end
    end

    // Pointers, occupancy and the registered not-empty flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            valid_r <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt     <= cnt_nxt;
            valid_r <= (cnt_nxt != '0);
        end
    end

    // Sticky overflow; a fresh blocked byte beats a concurrent clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_r <= 1'b0;
        end else if (blocked) begin
            ovf_r <= 1'b1;
        end else if (bus.clrOvf) begin
            ovf_r <= 1'b0;
        end
    end

    uart_fifo_mem #(
        .DWL   (DWL),
        .DEPTH (DEPTH)
    ) u_mem (
        .CLK   (CLK),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.rData),
        .raddr (rd_ptr),
        .rdata (bus.rdData)
    );

    assign bus.BUSY     = busy_r;
    assign bus.rdValid  = valid_r;
    assign bus.count    = cnt;
    assign bus.overflow = ovf_r;

endmodule
